// File: rtl/eth_frame_tx.sv
// eth_frame_tx: serializes an Ethernet header (dest MAC, src MAC, EtherType)
// followed by a byte-wide AXI-Stream payload into one AXI-Stream byte stream.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   hdr_valid/hdr_ready          header handshake
//   dest_mac, src_mac, eth_type  header fields, sampled at the handshake
//   s_tdata/s_tvalid/s_tready    payload input stream
//   s_tlast, s_tuser             end-of-frame and error flag of the payload
//   m_tdata/m_tvalid/m_tready    serialized output stream
//   m_tlast, m_tuser             end-of-frame and error flag of the output
//   busy                         a frame is in progress
module eth_frame_tx (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [47:0] dest_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] eth_type,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    input  logic        s_tuser,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic        busy
);

    localparam int unsigned HDR_BYTES = 14;
    localparam int unsigned SHIFT_W   = 8 * (HDR_BYTES - 1);
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_t;

    state_t               state;
    logic [SHIFT_W-1:0]   shift_reg;
    logic [CNT_W-1:0]     byte_cnt;
    logic                 ld;
    logic                 hdr_fire;
    logic                 pay_fire;

    // The output register may take a new byte when it is empty or draining.
    assign ld        = !m_tvalid || m_tready;
    assign hdr_ready = reset_n && (state == IDLE) && ld;
    assign s_tready  = reset_n && (state == PAYLOAD) && ld;
    assign hdr_fire  = hdr_valid && hdr_ready;
    assign pay_fire  = s_tvalid && s_tready;
    assign busy      = (state != IDLE);

    // Frame sequencing and the single output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            byte_cnt  <= '0;
            m_tdata   <= 8'h00;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            m_tuser   <= 1'b0;
        end else begin
            // A transferred beat empties the register unless refilled below.
            if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hdr_fire) begin
                        m_tdata   <= dest_mac[47:40];
                        m_tvalid  <= 1'b1;
                        m_tlast   <= 1'b0;
                        m_tuser   <= 1'b0;
                        shift_reg <= {dest_mac[39:0], src_mac, eth_type};
                        byte_cnt  <= CNT_W'(1);
                        state     <= HEADER;
                    end
                end

                HEADER: begin
                    if (ld) begin
                        m_tdata   <= shift_reg[SHIFT_W-1 -: 8];
                        m_tvalid  <= 1'b1;
                        m_tlast   <= 1'b0;
                        m_tuser   <= 1'b0;
                        shift_reg <= {shift_reg[SHIFT_W-9:0], 8'h00};
                        byte_cnt  <= byte_cnt + CNT_W'(1);
                        // byte_cnt names the header byte being loaded now.
                        if (byte_cnt == CNT_W'(HDR_BYTES - 1)) begin
                            state <= PAYLOAD;
                        end
                    end
                end

                PAYLOAD: begin
                    if (pay_fire) begin
                        m_tdata  <= s_tdata;
                        m_tvalid <= 1'b1;
                        m_tlast  <= s_tlast;
                        m_tuser  <= s_tuser;
                        if (s_tlast) begin
                            byte_cnt <= '0;
                            state    <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Self-checking bench for eth_frame_tx: directed frames from the test plan plus
// randomized frames, scored against an expected-beat queue built from the
// header fields and payload of each frame.
module tb_eth_frame_tx;

    localparam int unsigned LOG_N = 16384;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         idx;     // 0..13 header byte, 14+ payload byte
    } beat_t;

    logic        clk;
    logic        reset_n;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        s_tuser;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_xfer = 0;
    int rdy_mode = 0;         // 0: always ready, 1: toggle, 2: random

    beat_t exp_q[$];
    int    xfer_log [LOG_N];
    bit    vld_log  [LOG_N];
    bit    busy_log [LOG_N];
    bit    srdy_log [LOG_N];

    bit         stall_prev = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic       prev_user;

    eth_frame_tx dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hdr_valid (hdr_valid),
        .hdr_ready (hdr_ready),
        .dest_mac  (dest_mac),
        .src_mac   (src_mac),
        .eth_type  (eth_type),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .s_tuser   (s_tuser),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Downstream ready pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scores every transfer and the hold rule, logs per-cycle flags.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (cyc < LOG_N) begin
                vld_log[cyc]  = m_tvalid;
                busy_log[cyc] = busy;
                srdy_log[cyc] = s_tready;
            end
            if (stall_prev) begin
                check("hold_valid", 64'(m_tvalid), 64'(1));
                check("hold_data", 64'(m_tdata), 64'(prev_data));
                check("hold_last", 64'(m_tlast), 64'(prev_last));
                check("hold_user", 64'(m_tuser), 64'(prev_user));
            end
            // Payload may only be taken once all header bytes of this frame are loaded.
            if (exp_q.size() == 0 || exp_q[0].idx < 13) begin
                check("s_tready_in_header", 64'(s_tready), 64'(0));
            end
            if (m_tvalid && m_tready) begin
                check("beat_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", 64'(m_tdata), 64'(e.data));
                    check("beat_last", 64'(m_tlast), 64'(e.last));
                    check("beat_user", 64'(m_tuser), 64'(e.user));
                end
                if (n_xfer < LOG_N) xfer_log[n_xfer] = cyc;
                n_xfer++;
            end
            stall_prev = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            prev_user  = m_tuser;
        end
    end

    // Reference model: the wire image of one frame.
    task automatic push_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input logic [7:0] pl[$], input logic usr);
        logic [111:0] h;
        beat_t b;
        h = {d, s, t};
        for (int k = 0; k < 14; k++) begin
            b.data = h[111 - 8*k -: 8];
            b.last = 1'b0;
            b.user = 1'b0;
            b.idx  = k;
            exp_q.push_back(b);
        end
        for (int j = 0; j < pl.size(); j++) begin
            b.data = pl[j];
            b.last = (j == pl.size() - 1);
            b.user = (j == pl.size() - 1) ? usr : 1'b0;
            b.idx  = 14 + j;
            exp_q.push_back(b);
        end
    endtask

    task automatic do_header(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                             output int hs);
        bit acc;
        int n;
        dest_mac  = d;
        src_mac   = s;
        eth_type  = t;
        hdr_valid = 1'b1;
        n = 0;
        hs = -1;
        do begin
            @(negedge clk);
            acc = hdr_ready;
            hs  = cyc;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 300);
        check("hdr_handshake", 64'(acc), 64'(1));
        hdr_valid = 1'b0;
        // Scramble the fields: they must have been captured at the handshake.
        dest_mac = 48'({$urandom(), $urandom()});
        src_mac  = 48'({$urandom(), $urandom()});
        eth_type = 16'($urandom());
    endtask

    task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input logic [7:0] pl[$], input logic usr,
                              input bit early, input bit sv_rand, output int hs);
        int j;
        int n;
        bit acc;
        push_frame(d, s, t, pl, usr);
        if (early) begin
            s_tvalid = 1'b1;
            s_tdata  = pl[0];
            s_tlast  = (pl.size() == 1);
            s_tuser  = (pl.size() == 1) ? usr : 1'b0;
        end
        do_header(d, s, t, hs);
        j = 0;
        n = 0;
        while (j < pl.size() && n < 3000) begin
            if (!s_tvalid && (!sv_rand || $urandom_range(0, 1) == 1)) begin
                s_tvalid = 1'b1;
                s_tdata  = pl[j];
                s_tlast  = (j == pl.size() - 1);
                s_tuser  = (j == pl.size() - 1) ? usr : 1'b0;
            end
            @(negedge clk);
            acc = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            if (acc) begin
                j++;
                s_tvalid = 1'b0;
                s_tdata  = 8'($urandom());
                s_tlast  = 1'b0;
                s_tuser  = 1'b0;
            end
            n++;
        end
        check("payload_sent", 64'(j), 64'(pl.size()));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [7:0] pl_basic[$];
    logic [7:0] pl_one[$];
    logic [7:0] pl_two[$];
    logic [7:0] pl_rnd[$];

    initial begin
        int hs;
        int hs2;
        int base;
        int gaps;
        int n;
        pl_basic = '{8'h01, 8'h02, 8'h03};
        pl_one   = '{8'h5A};
        pl_two   = '{8'hC3, 8'h3C};

        // Reset, with valids high to show the readies are gated by reset.
        reset_n   = 1'b0;
        hdr_valid = 1'b1;
        dest_mac  = 48'h0;
        src_mac   = 48'h0;
        eth_type  = 16'h0;
        s_tvalid  = 1'b1;
        s_tdata   = 8'h00;
        s_tlast   = 1'b0;
        s_tuser   = 1'b0;
        m_tready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hdr_ready", 64'(hdr_ready), 64'(0));
        check("rst_s_tready", 64'(s_tready), 64'(0));
        check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_m_tdata", 64'(m_tdata), 64'(0));
        check("rst_m_tlast", 64'(m_tlast), 64'(0));
        check("rst_m_tuser", 64'(m_tuser), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        hdr_valid = 1'b0;
        s_tvalid  = 1'b0;
        reset_n   = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame with latency and busy window.
        rdy_mode = 0;
        base = n_xfer;
        send_frame(48'h112233445566, 48'hAABBCCDDEEFF, 16'h0800, pl_basic, 1'b0, 1'b0, 1'b0, hs);
        wait_drain();
        check("basic_beats", 64'(n_xfer - base), 64'(17));
        for (int k = 0; k < 17; k++) begin
            check("basic_latency", 64'(xfer_log[base + k]), 64'(hs + 1 + k));
        end
        gaps = 0;
        for (int c = hs + 1; c <= hs + 16; c++) if (!busy_log[c]) gaps++;
        check("basic_busy_high", 64'(gaps), 64'(0));
        check("basic_busy_end", 64'(busy_log[hs + 17]), 64'(0));

        // Backpressure: toggling ready, random upstream valid.
        rdy_mode = 1;
        base = n_xfer;
        send_frame(48'h112233445566, 48'hAABBCCDDEEFF, 16'h0800, pl_basic, 1'b0, 1'b0, 1'b1, hs);
        wait_drain();
        check("bp_beats", 64'(n_xfer - base), 64'(17));

        // One-byte payload with error flag.
        rdy_mode = 0;
        base = n_xfer;
        send_frame(48'hDEADBEEF0001, 48'h020000000002, 16'h86DD, pl_one, 1'b1, 1'b0, 1'b0, hs);
        wait_drain();
        check("one_beats", 64'(n_xfer - base), 64'(15));

        // Back-to-back frames, no bubble between them.
        rdy_mode = 0;
        send_frame(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0806, pl_two, 1'b0, 1'b0, 1'b0, hs);
        send_frame(48'h111111111111, 48'h222222222222, 16'h88B5, pl_two, 1'b1, 1'b0, 1'b0, hs2);
        wait_drain();
        check("b2b_second_hdr", 64'(hs2), 64'(hs + 16));
        gaps = 0;
        for (int c = hs + 1; c <= hs + 32; c++) if (!vld_log[c]) gaps++;
        check("b2b_gaps", 64'(gaps), 64'(0));

        // Early payload: s_tvalid high before the header handshake.
        rdy_mode = 0;
        base = n_xfer;
        send_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, pl_basic, 1'b0, 1'b1, 1'b0, hs);
        wait_drain();
        gaps = 0;
        for (int c = hs; c <= hs + 13; c++) if (srdy_log[c]) gaps++;
        check("early_s_tready_low", 64'(gaps), 64'(0));
        check("early_first_payload", 64'(xfer_log[base + 14]), 64'(hs + 15));

        // Reset in the middle of the header.
        rdy_mode = 0;
        base = n_xfer;
        pl_rnd = '{8'h77};
        push_frame(48'hCAFECAFECAFE, 48'hFACEFACEFACE, 16'h0800, pl_rnd, 1'b0);
        do_header(48'hCAFECAFECAFE, 48'hFACEFACEFACE, 16'h0800, hs);
        n = 0;
        while (n_xfer < base + 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_reset_reach", 64'(n_xfer >= base + 7), 64'(1));
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        hdr_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_hdr_ready", 64'(hdr_ready), 64'(0));
        check("mid_rst_s_tready", 64'(s_tready), 64'(0));
        @(posedge clk);
        #1;
        hdr_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        check("mid_rst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        base = n_xfer;
        send_frame(48'h112233445566, 48'hAABBCCDDEEFF, 16'h0800, pl_basic, 1'b0, 1'b0, 1'b0, hs);
        wait_drain();
        check("post_rst_beats", 64'(n_xfer - base), 64'(17));

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            int len;
            rdy_mode = $urandom_range(0, 2);
            len = $urandom_range(1, 24);
            pl_rnd.delete();
            for (int j = 0; j < len; j++) pl_rnd.push_back(8'($urandom()));
            send_frame(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
                       16'($urandom()), pl_rnd, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hs);
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
